// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and the round-robin pick function for the edge event arbiter.
// rr_pick works on a 16-bit request vector so one definition serves every channel count.
package edge_evt_pkg;

    typedef enum logic {EVT_RISE = 1'b0, EVT_FALL = 1'b1} evt_type_t;
    typedef enum logic {S_IDLE, S_HOLD} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Search order is ptr+1, ptr+2, ... wrapping at n. The loop runs backwards so the
    // last assignment made is the earliest hit in that order.
    function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
        pick_t      p;
        int         c;
        logic [3:0] c4;
        p.found = 1'b0;
        p.idx   = 4'd0;
        for (int i = 16; i >= 1; i--) begin
            if (i <= n) begin
                c  = (int'(ptr) + i) % n;
                c4 = 4'(c);
                if (req[c4]) begin
                    p.found = 1'b1;
                    p.idx   = c4;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin pick over N_CH request bits, starting after ptr.
module rr_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] idx,
    output logic            found
);

    pick_t pick;

    always_comb begin
        pick = rr_pick(16'(req), 4'(ptr), N_CH);
    end

    assign found = pick.found;
    assign idx   = CH_W'(pick.idx);

endmodule

// File: rtl/edge_event_arbiter.sv
// Records rise/fall edge pulses per channel as pending events and serialises them
// onto one valid/ready channel by round-robin arbitration, with sticky overflow flags.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk50m,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] rise,
    input  logic [N_CH-1:0] fall,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_fall,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr,
    output logic            busy
);

    logic [N_CH-1:0] pend_r;
    logic [N_CH-1:0] pend_f;
    logic [N_CH-1:0] first_f;
    arb_state_t      state;
    logic [CH_W-1:0] ptr;

    logic            found;
    logic [CH_W-1:0] win_ch;
    evt_type_t       win_type;
    logic            load;
    logic [N_CH-1:0] win_1h;
    logic [N_CH-1:0] grant_r;
    logic [N_CH-1:0] grant_f;
    logic [N_CH-1:0] pend_r_eff;
    logic [N_CH-1:0] ovf_set;

    rr_arbiter #(.N_CH(N_CH)) u_rr (
        .req   (pend_r | pend_f),
        .ptr   (ptr),
        .idx   (win_ch),
        .found (found)
    );

    // In HOLD a new winner may only be loaded on the cycle the current event is accepted.
    always_comb begin
        win_type   = (first_f[win_ch] || !pend_r[win_ch]) ? EVT_FALL : EVT_RISE;
        load       = en && found && (state == S_IDLE || evt_ready);
        win_1h     = N_CH'(1) << win_ch;
        grant_r    = (load && win_type == EVT_RISE) ? win_1h : '0;
        grant_f    = (load && win_type == EVT_FALL) ? win_1h : '0;
        pend_r_eff = pend_r & ~grant_r;
        ovf_set    = (rise & pend_r & ~grant_r) | (fall & pend_f & ~grant_f);
    end

    // A fall is "first" only if no rise is left pending after this edge's grant.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            pend_r  <= '0;
            pend_f  <= '0;
            first_f <= '0;
            ovf     <= '0;
        end else begin
            pend_r  <= pend_r_eff | rise;
            pend_f  <= (pend_f & ~grant_f) | fall;
            first_f <= (first_f & ~grant_f) | (fall & ~pend_r_eff & ~rise);
            ovf     <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_fall  <= 1'b0;
            ptr       <= CH_W'(N_CH - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        evt_valid <= 1'b1;
                        evt_ch    <= win_ch;
                        evt_fall  <= (win_type == EVT_FALL);
                        ptr       <= win_ch;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (load) begin
                        evt_ch   <= win_ch;
                        evt_fall <= (win_type == EVT_FALL);
                        ptr      <= win_ch;
                    end else if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = evt_valid | (|(pend_r | pend_f));

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed testbench for edge_event_arbiter with N_CH=4; each task checks its own scenario.
module tb_edge_event_arbiter;

    logic       clk50m = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_fall;
    logic [3:0] ovf;
    logic       ovf_clr;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk50m    (clk50m),
        .rst_n     (rst_n),
        .en        (en),
        .rise      (rise),
        .fall      (fall),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_fall  (evt_fall),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    always #10 clk50m = ~clk50m;

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic pulse(input logic [3:0] r, input logic [3:0] f);
        rise = r;
        fall = f;
        tick();
        rise = '0;
        fall = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        evt_ready = 1'b1;
        rise      = '0;
        fall      = '0;
        ovf_clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_fall} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0000", {evt_valid, evt_ch, evt_fall});
        end
        n_cmp++;
        if ({ovf, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ovf_busy: got %b want 00000", {ovf, busy});
        end
    endtask

    task automatic test_single();
        do_reset();
        pulse(4'b0100, 4'b0000);
        n_cmp++;
        if ({evt_valid, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL single_pending: got valid/busy %b want 01", {evt_valid, busy});
        end
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_fall} !== 4'b1100) begin
            n_bad++;
            $display("FAIL single_event: got %b want 1100", {evt_valid, evt_ch, evt_fall});
        end
        tick();
        n_cmp++;
        if ({evt_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL single_done: got valid/busy %b want 00", {evt_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp1 [3];
        logic [3:0] exp2 [2];
        exp1 = '{4'b1000, 4'b1010, 4'b1110};
        exp2 = '{4'b1000, 4'b1110};
        do_reset();
        pulse(4'b1011, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({evt_valid, evt_ch, evt_fall} !== exp1[i]) begin
                n_bad++;
                $display("FAIL b2b_burst%0d: got %b want %b", i, {evt_valid, evt_ch, evt_fall}, exp1[i]);
            end
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_burst_end: got valid %b want 0", evt_valid);
        end
        pulse(4'b1001, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({evt_valid, evt_ch, evt_fall} !== exp2[i]) begin
                n_bad++;
                $display("FAIL b2b_wrap%0d: got %b want %b", i, {evt_valid, evt_ch, evt_fall}, exp2[i]);
            end
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_wrap_end: got valid %b want 0", evt_valid);
        end
    endtask

    task automatic test_backpressure();
        int bad_cycles;
        do_reset();
        evt_ready = 1'b0;
        pulse(4'b0010, 4'b0000);
        tick();
        bad_cycles = 0;
        for (int i = 0; i < 18; i++) begin
            if ({evt_valid, evt_ch, evt_fall} !== 4'b1010) bad_cycles++;
            tick();
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0 (last %b, want 1010)",
                     bad_cycles, {evt_valid, evt_ch, evt_fall});
        end
        evt_ready = 1'b1;
        tick();
        n_cmp++;
        if ({evt_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_accept: got valid/busy %b want 00", {evt_valid, busy});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1'b0;
        pulse(4'b0010, 4'b0000);
        tick();
        n_cmp++;
        if (ovf !== 4'b0000) begin
            n_bad++;
            $display("FAIL ovf_none: got %b want 0000", ovf);
        end
        pulse(4'b0010, 4'b0000);
        n_cmp++;
        if (ovf !== 4'b0010) begin
            n_bad++;
            $display("FAIL ovf_set: got %b want 0010", ovf);
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_fall} !== 4'b1010) begin
            n_bad++;
            $display("FAIL ovf_event: got %b want 1010", {evt_valid, evt_ch, evt_fall});
        end
        tick();
        n_cmp++;
        if ({evt_valid, ovf} !== 5'b0_0010) begin
            n_bad++;
            $display("FAIL ovf_single_event: got valid/ovf %b want 00010", {evt_valid, ovf});
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 4'b0000) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b want 0000", ovf);
        end
        en = 1'b0;
        pulse(4'b0100, 4'b0000);
        ovf_clr = 1'b1;
        pulse(4'b0100, 4'b0000);
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 4'b0100) begin
            n_bad++;
            $display("FAIL ovf_set_wins: got %b want 0100", ovf);
        end
    endtask

    task automatic test_grant_collision();
        do_reset();
        pulse(4'b0001, 4'b0000);
        pulse(4'b0001, 4'b0000);
        n_cmp++;
        if ({evt_valid, evt_ch, evt_fall, ovf} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL coll_first: got %b want 10000000", {evt_valid, evt_ch, evt_fall, ovf});
        end
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_fall, ovf} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL coll_second: got %b want 10000000", {evt_valid, evt_ch, evt_fall, ovf});
        end
        tick();
        n_cmp++;
        if ({evt_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL coll_end: got valid/busy %b want 00", {evt_valid, busy});
        end
    endtask

    task automatic test_ordering();
        logic [3:0] exp [2];
        do_reset();
        en = 1'b0;
        pulse(4'b0000, 4'b0001);
        tick();
        pulse(4'b0001, 4'b0000);
        tick();
        en = 1'b1;
        exp = '{4'b1001, 4'b1000};
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({evt_valid, evt_ch, evt_fall} !== exp[i]) begin
                n_bad++;
                $display("FAIL order_fall_first%0d: got %b want %b", i, {evt_valid, evt_ch, evt_fall}, exp[i]);
            end
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL order_end: got valid %b want 0", evt_valid);
        end
        pulse(4'b0001, 4'b0001);
        exp = '{4'b1000, 4'b1001};
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({evt_valid, evt_ch, evt_fall} !== exp[i]) begin
                n_bad++;
                $display("FAIL order_simul%0d: got %b want %b", i, {evt_valid, evt_ch, evt_fall}, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int bad_cycles;
        do_reset();
        evt_ready = 1'b0;
        pulse(4'b0101, 4'b0000);
        tick();
        pulse(4'b0100, 4'b0000);
        n_cmp++;
        if ({evt_valid, evt_ch, ovf, busy} !== 8'b1_00_0100_1) begin
            n_bad++;
            $display("FAIL arst_before: got %b want 10001001", {evt_valid, evt_ch, ovf, busy});
        end
        #5;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({evt_valid, ovf, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL arst_immediate: got %b want 000000", {evt_valid, ovf, busy});
        end
        tick();
        rst_n = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_valid !== 1'b0 || busy !== 1'b0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL arst_quiet: got %0d active cycles want 0", bad_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_grant_collision();
        test_ordering();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
